dataload_ctrl: RTL and testbench
================================

Name: dataload_ctrl

Overview:
Sequencer in front of the dataload block. It pulls 32-bit words from an upstream valid/ready stream and steers them into dataload as input or weight loads, one tile at a time. Per tile it loads INPUT_WORDS input words and waits for input_valid_i. It then loads WEIGHT_WORDS weight words one at a time, waiting for the consumer ack after each, and finally launches and waits for compute. It runs num_tiles_i tiles per start command.

Parameters:
WORD_W, 32, data word width (matches dataload data_i)
INPUT_WORDS, 8, words per input fill (256-bit first-level input)
WEIGHT_WORDS, 16, weight words per tile
TILE_W, 16, width of tile count
TIMEOUT_CYC, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  start command, sampled only in IDLE
num_tiles_i  in  TILE_W  tiles to run, sampled with start_i
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse when the command completes
src_data_i  in  WORD_W  upstream word
src_valid_i  in  1  upstream word valid
src_ready_o  out  1  controller can accept a word this cycle
load_en_o  out  1  to dataload load_en_i
load_type_o  out  1  to dataload load_type (0 = weight, 1 = input)
load_data_o  out  WORD_W  to dataload data_i
input_valid_i  in  1  from dataload input_valid
weight_valid_i  in  1  from dataload weight_valid
weight_ack_i  in  1  downstream consumed current weight
compute_start_o  out  1  one-cycle pulse, launch tile compute
compute_done_i  in  1  tile compute finished
tile_cnt_o  out  TILE_W  tiles completed in the current command

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, counters 0. Reset mid-operation abandons the tile; no loads after reset.
- FSM states: IDLE, LOAD_I, WAIT_I, LOAD_W, WAIT_W, COMPUTE, WAIT_C, DONE.
- IDLE:
  - start_i=1 and num_tiles_i!=0: latch the count, busy_o=1, go to LOAD_I.
  - start_i=1 and num_tiles_i==0: go to DONE, no loads.
- Accept rule: a word is accepted when src_valid_i & src_ready_o.
  - src_ready_o is combinational and is 1 only in LOAD_I, or in LOAD_W while no weight is outstanding.
- Load latency: a word accepted in cycle N appears in cycle N+1 as load_en_o=1, with load_type_o and load_data_o registered. load_en_o is a single-cycle pulse per word.
- LOAD_I:
  - Count accepts with load_type 1.
  - After the INPUT_WORDS-th accept, go to WAIT_I; src_ready_o drops the same cycle, so word 9 is never taken.
- WAIT_I: wait for input_valid_i=1, then go to LOAD_W with the weight count at 0.
- LOAD_W: accept exactly one word (load_type 0), then go to WAIT_W.
- WAIT_W:
  - Advance only when weight_valid_i & weight_ack_i are both 1 in the same cycle.
  - Then increment the weight count. Go to COMPUTE when it equals WEIGHT_WORDS, else back to LOAD_W.
  - weight_ack_i without weight_valid_i is ignored.
- COMPUTE: compute_start_o=1 for one cycle, then go to WAIT_C.
- WAIT_C:
  - On compute_done_i=1, increment tile_cnt_o.
  - If tile_cnt_o+1==latched count, go to DONE; else go to LOAD_I.
- DONE: done_o=1 for one cycle, busy_o=0 next cycle, go to IDLE. tile_cnt_o holds until the next accepted start, which clears it.
- Ignored inputs:
  - start_i while busy.
  - compute_done_i outside WAIT_C.
  - input_valid_i outside WAIT_I.
- Idle upstream: src_valid_i low stalls the FSM indefinitely with no timeout unless the optional feature is enabled.
- Counters: the input counter is clog2(INPUT_WORDS+1) bits and the weight counter is clog2(WEIGHT_WORDS+1) bits. No wrap occurs within a tile.

Optional Feature:
DATALOAD_CTRL_TIMEOUT_EN.
- Defined: adds output error_o (1 bit, sticky, cleared by rst or an accepted start).
  - A watchdog counts consecutive cycles in WAIT_I, WAIT_W or WAIT_C and clears on every state change.
  - On reaching TIMEOUT_CYC, error_o=1, a done_o pulse fires, and the FSM goes to IDLE.
- Undefined: no watchdog, no error_o port, and waits are unbounded.

Decomposition:
- Shared package dataload_ctrl_pkg holds:
  - the state enum (typedef, 3-bit encoding);
  - constants for the load_type encoding (LOAD_WEIGHT=0, LOAD_INPUT=1);
  - default WORD_W and INPUT_WORDS.
- One natural sub-module: dataload_ctrl_wdog, the watchdog counter, instantiated only under the macro.
- The FSM and counters stay in the top module.

Test Plan:
- num_tiles=1, src_valid always 1, ack and done immediate -> 8 load_en pulses with type 1, then 16 pulses with type 0, each separated by the WAIT_W ack; 1 compute_start; done_o; tile_cnt_o=1.
- Input fill with src_valid held high through word 9 -> exactly 8 accepts, src_ready_o=0 in the cycle after the 8th accept, and no further type-1 loads until input_valid_i.
- weight_ack_i held 0 for 20 cycles in WAIT_W -> src_ready_o stays 0 and no second weight load; ack=1 with weight_valid=1 resumes.
- start with num_tiles=0 -> no load_en or compute_start, done_o pulses within 2 cycles, busy_o clears.
- num_tiles=3 with a second start_i mid-run, then rst asserted during tile 2's LOAD_W -> second start ignored; all outputs 0 immediately on rst and FSM in IDLE; a fresh start runs cleanly.
- With DATALOAD_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, compute_done_i never asserted -> error_o=1 and done_o pulse 16 cycles into WAIT_C, FSM back in IDLE.

Source files
------------

// File: rtl/dataload_ctrl_pkg.sv
// Shared types and constants for the dataload sequencer.
//   state_t      : sequencer state encoding (3 bits)
//   LOAD_WEIGHT / LOAD_INPUT : load_type encoding driven to dataload
//   DEF_WORD_W / DEF_INPUT_WORDS : default data width and input fill depth
//   is_wait()    : true for the states that block on a downstream handshake
package dataload_ctrl_pkg;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_INPUT_WORDS = 8;

  localparam logic LOAD_WEIGHT = 1'b0;
  localparam logic LOAD_INPUT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_I  = 3'd1,
    ST_WAIT_I  = 3'd2,
    ST_LOAD_W  = 3'd3,
    ST_WAIT_W  = 3'd4,
    ST_COMPUTE = 3'd5,
    ST_WAIT_C  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == ST_WAIT_I) || (s == ST_WAIT_W) || (s == ST_WAIT_C);
  endfunction

endpackage

// File: rtl/dataload_ctrl_wdog.sv
// Watchdog for the sequencer's handshake waits.
// Counts consecutive cycles spent in one wait state; the count restarts on
// any state change. expired is high during the TIMEOUT_CYC-th such cycle, so
// the FSM leaves on the edge that ends it.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   state    : current sequencer state
//   expired  : combinational timeout indication
module dataload_ctrl_wdog
  import dataload_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic   clk,
  input  logic   rst,
  input  state_t state,
  output logic   expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  state_t        last;
  logic          waiting;

  // cnt_eff is the number of earlier cycles already spent in this same state
  always_comb begin
    waiting = is_wait(state);
    cnt_eff = (waiting && (state == last)) ? cnt : '0;
    expired = waiting && (cnt_eff == CW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      last <= ST_IDLE;
    end else begin
      last <= state;
      cnt  <= waiting ? cnt_eff + CW'(1) : '0;
    end
  end

endmodule

// File: rtl/dataload_ctrl.sv
// Sequencer in front of dataload: pulls words from an upstream valid/ready
// stream and steers them into dataload, one tile at a time:
//   INPUT_WORDS input loads -> wait input_valid_i ->
//   WEIGHT_WORDS x (one weight load -> wait weight_valid_i & weight_ack_i) ->
//   compute_start_o pulse -> wait compute_done_i
// repeated num_tiles_i times per start command.
// Optional build macro DATALOAD_CTRL_TIMEOUT_EN adds a watchdog on the three
// wait states and a sticky error_o output.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_i, num_tiles_i: command (sampled in IDLE only)
//   busy_o, done_o      : command status, done_o is a one-cycle pulse
//   src_*               : upstream valid/ready word stream
//   load_en/type/data_o : registered load interface to dataload
//   input_valid_i, weight_valid_i, weight_ack_i : dataload / consumer status
//   compute_start_o, compute_done_i : per-tile compute handshake
//   tile_cnt_o          : tiles completed in the current command
//   error_o             : watchdog expiry (macro builds only)
module dataload_ctrl
  import dataload_ctrl_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int INPUT_WORDS  = DEF_INPUT_WORDS,
  parameter int WEIGHT_WORDS = 16,
  parameter int TILE_W       = 16
`ifdef DATALOAD_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [TILE_W-1:0] num_tiles_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [WORD_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic              load_en_o,
  output logic              load_type_o,
  output logic [WORD_W-1:0] load_data_o,
  input  logic              input_valid_i,
  input  logic              weight_valid_i,
  input  logic              weight_ack_i,
  output logic              compute_start_o,
  input  logic              compute_done_i,
  output logic [TILE_W-1:0] tile_cnt_o
`ifdef DATALOAD_CTRL_TIMEOUT_EN
  , output logic            error_o
`endif
);

  localparam int IW = $clog2(INPUT_WORDS + 1);
  localparam int WW = $clog2(WEIGHT_WORDS + 1);

  state_t            state;
  logic [IW-1:0]     icnt;
  logic [WW-1:0]     wcnt;
  logic [TILE_W-1:0] num_tiles;
  logic [TILE_W-1:0] tile_nxt;
  logic              accept;
  logic              timeout;

  // LOAD_W accepts a single word and leaves immediately, so no weight is ever
  // outstanding while in LOAD_W; the state alone decides readiness.
  assign src_ready_o = (state == ST_LOAD_I) || (state == ST_LOAD_W);
  assign accept      = src_valid_i && src_ready_o;
  assign tile_nxt    = tile_cnt_o + TILE_W'(1);

`ifdef DATALOAD_CTRL_TIMEOUT_EN
  dataload_ctrl_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .state  (state),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      compute_start_o <= 1'b0;
      tile_cnt_o      <= '0;
      num_tiles       <= '0;
      icnt            <= '0;
      wcnt            <= '0;
      load_en_o       <= 1'b0;
      load_type_o     <= 1'b0;
      load_data_o     <= '0;
`ifdef DATALOAD_CTRL_TIMEOUT_EN
      error_o         <= 1'b0;
`endif
    end else begin
      // pulses default low; load_en_o follows the accept one cycle later
      done_o          <= 1'b0;
      compute_start_o <= 1'b0;
      load_en_o       <= accept;
      if (accept) begin
        load_type_o <= (state == ST_LOAD_I) ? LOAD_INPUT : LOAD_WEIGHT;
        load_data_o <= src_data_i;
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            busy_o     <= 1'b1;
            tile_cnt_o <= '0;
            num_tiles  <= num_tiles_i;
            icnt       <= '0;
`ifdef DATALOAD_CTRL_TIMEOUT_EN
            error_o    <= 1'b0;
`endif
            if (num_tiles_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state <= ST_LOAD_I;
            end
          end
        end

        ST_LOAD_I: begin
          if (accept) begin
            icnt <= icnt + IW'(1);
            if (icnt == IW'(INPUT_WORDS - 1)) state <= ST_WAIT_I;
          end
        end

        ST_WAIT_I: begin
          if (input_valid_i) begin
            wcnt  <= '0;
            state <= ST_LOAD_W;
          end
        end

        ST_LOAD_W: begin
          if (accept) state <= ST_WAIT_W;
        end

        ST_WAIT_W: begin
          // an ack without a loaded weight is meaningless and dropped
          if (weight_valid_i && weight_ack_i) begin
            wcnt <= wcnt + WW'(1);
            if (wcnt == WW'(WEIGHT_WORDS - 1)) begin
              state           <= ST_COMPUTE;
              compute_start_o <= 1'b1;
            end else begin
              state <= ST_LOAD_W;
            end
          end
        end

        // compute_start_o is high for exactly this state's cycle
        ST_COMPUTE: state <= ST_WAIT_C;

        ST_WAIT_C: begin
          if (compute_done_i) begin
            tile_cnt_o <= tile_nxt;
            if (tile_nxt == num_tiles) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              icnt  <= '0;
              state <= ST_LOAD_I;
            end
          end
        end

        // done_o is high during this state; busy_o drops on leaving it
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

`ifdef DATALOAD_CTRL_TIMEOUT_EN
      // a stuck wait abandons the command and reports it
      if (timeout) begin
        state   <= ST_IDLE;
        busy_o  <= 1'b0;
        done_o  <= 1'b1;
        error_o <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dataload_ctrl.sv
// Self-checking bench for dataload_ctrl.
// A table of command records is replayed; each command is driven with
// (optionally randomized) upstream traffic and responder delays while a
// transaction-level model, built from per-tile word counts, predicts every
// cycle's outputs. Totals per command are then compared with the table.
module tb_dataload_ctrl;
  import dataload_ctrl_pkg::*;

  localparam int WORD_W = 32;
  localparam int TILE_W = 16;
  localparam int IN_W   = 8;
  localparam int WT_W   = 16;
  localparam int BUDGET = 5000;
`ifdef DATALOAD_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 32;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [TILE_W-1:0] num_tiles_i = '0;
  logic              busy_o, done_o;
  logic [WORD_W-1:0] src_data_i = '0;
  logic              src_valid_i = 1'b0;
  logic              src_ready_o;
  logic              load_en_o, load_type_o;
  logic [WORD_W-1:0] load_data_o;
  logic              input_valid_i = 1'b0;
  logic              weight_valid_i = 1'b0;
  logic              weight_ack_i = 1'b0;
  logic              compute_start_o;
  logic              compute_done_i = 1'b0;
  logic [TILE_W-1:0] tile_cnt_o;
`ifdef DATALOAD_CTRL_TIMEOUT_EN
  logic              error_o;
`endif

  always #5 clk = ~clk;

  dataload_ctrl #(
    .WORD_W(WORD_W), .INPUT_WORDS(IN_W), .WEIGHT_WORDS(WT_W), .TILE_W(TILE_W)
`ifdef DATALOAD_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_tiles_i(num_tiles_i),
    .busy_o(busy_o), .done_o(done_o),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .load_en_o(load_en_o), .load_type_o(load_type_o), .load_data_o(load_data_o),
    .input_valid_i(input_valid_i), .weight_valid_i(weight_valid_i),
    .weight_ack_i(weight_ack_i), .compute_start_o(compute_start_o),
    .compute_done_i(compute_done_i), .tile_cnt_o(tile_cnt_o)
`ifdef DATALOAD_CTRL_TIMEOUT_EN
    , .error_o(error_o)
`endif
  );

  // n tiles; rnd = random valid gaps/noise; dly = responder delay (-1 random);
  // restart = cycle of an extra start while busy (-1 none); rst_mid = reset in
  // tile 2 LOAD_W after 4 weights; e_* = expected totals for the command
  typedef struct {
    int n; bit rnd; int dly; int restart; bit rst_mid;
    int e_in; int e_w; int e_comp; int e_tile; int e_done;
  } vec_t;

  vec_t vecs[7];
  int n_chk = 0, n_pass = 0;
  int cnt_in, cnt_w, cnt_comp, cnt_done, last_tile;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pick(input vec_t v);
    return (v.dly >= 0) ? v.dly : int'($urandom_range(0, 4));
  endfunction

  task automatic idle_inputs();
    start_i = 1'b0; src_valid_i = 1'b0; src_data_i = '0;
    input_valid_i = 1'b0; weight_valid_i = 1'b0; weight_ack_i = 1'b0;
    compute_done_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_load_en"}, load_en_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cstart"}, compute_start_o, 0);
    chk({tag, "_ready"}, src_ready_o, 0);
    chk({tag, "_tile_cnt"}, tile_cnt_o, 0);
    chk({tag, "_load_type"}, load_type_o, 0);
    chk({tag, "_load_data"}, load_data_o, 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int in_acc = 0, w_acc = 0, w_ack = 0, tiles = 0;
    int iv_wait = 0, wa_wait = 0, cd_wait = 0;
    bit iv_seen = 0, busy_e = 1, fin = 0, ended = 0;
    bit p_acc = 0, p_iv = 0, p_wa = 0, p_cd = 0;
    logic [WORD_W-1:0] p_data = '0;
    bit e_load, e_type, e_cs, e_done, e_rdy;
    cnt_in = 0; cnt_w = 0; cnt_comp = 0; cnt_done = 0; last_tile = 0;
    @(negedge clk);
    start_i = 1'b1; num_tiles_i = TILE_W'(v.n);
    for (int cyc = 0; cyc < BUDGET && !ended; cyc++) begin
      @(negedge clk);
      // apply what the previous edge consumed
      e_load = p_acc; e_type = 0; e_cs = 0; e_done = 0;
      if (fin) busy_e = 0;
      if (cyc == 0 && v.n == 0) e_done = 1;
      if (p_acc) begin
        e_type = (in_acc < IN_W);
        if (e_type) begin in_acc++; if (in_acc == IN_W) iv_wait = pick(v); end
        else begin w_acc++; wa_wait = pick(v); end
      end
      if (p_iv) iv_seen = 1;
      if (p_wa) begin
        w_ack++;
        if (w_ack == WT_W) begin e_cs = 1; cd_wait = pick(v); end
      end
      if (p_cd) begin
        tiles++; in_acc = 0; iv_seen = 0; w_acc = 0; w_ack = 0;
        if (tiles == v.n) e_done = 1;
      end
      e_rdy = busy_e && (tiles < v.n) &&
              ((in_acc < IN_W) || (iv_seen && w_acc == w_ack && w_acc < WT_W));

      chk("src_ready", src_ready_o, e_rdy);
      chk("load_en", load_en_o, e_load);
      if (e_load) begin
        chk("load_type", load_type_o, e_type);
        chk("load_data", load_data_o, p_data);
      end
      chk("compute_start", compute_start_o, e_cs);
      chk("done", done_o, e_done);
      chk("busy", busy_o, busy_e);
      chk("tile_cnt", tile_cnt_o, tiles);
      if (load_en_o) begin if (load_type_o) cnt_in++; else cnt_w++; end
      cnt_comp += int'(compute_start_o);
      cnt_done += int'(done_o);
      last_tile = int'(tile_cnt_o);
      if (fin) ended = 1;
      else if (e_done) fin = 1;

      if (v.rst_mid && tiles == 1 && iv_seen && w_acc == 4 && w_ack == 4) begin
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (3) begin @(negedge clk); chk_zero("rst_hold"); end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); chk_zero("post_rst"); end
        return;
      end

      if (!ended) begin
        src_valid_i = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        src_data_i  = $urandom();
        start_i     = (cyc == v.restart);
        if (start_i) num_tiles_i = TILE_W'(1);
        p_acc  = src_valid_i && e_rdy;
        p_data = src_data_i;
        p_iv = 0;
        if (busy_e && in_acc == IN_W && !iv_seen) begin
          if (iv_wait == 0) p_iv = 1; else iv_wait--;
          input_valid_i = p_iv;
        end else input_valid_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        p_wa = 0;
        if (w_acc > w_ack) begin
          weight_valid_i = 1'b1;
          if (wa_wait == 0) p_wa = 1; else wa_wait--;
          weight_ack_i = p_wa;
        end else begin
          weight_valid_i = 1'b0;
          weight_ack_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        p_cd = 0;
        if (w_ack == WT_W && !e_cs) begin
          if (cd_wait == 0) p_cd = 1; else cd_wait--;
          compute_done_i = p_cd;
        end else compute_done_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    idle_inputs();
    if (!ended) chk("cmd_complete_within_budget", 0, 1);
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, -1, 0, 8, 16, 1, 1, 1};
    vecs[1] = '{0, 0, 0, -1, 0, 0, 0, 0, 0, 1};
    vecs[2] = '{1, 0, 20, -1, 0, 8, 16, 1, 1, 1};
    vecs[3] = '{2, 1, -1, -1, 0, 16, 32, 2, 2, 1};
    vecs[4] = '{3, 0, 0, 30, 1, 16, 20, 1, 1, 0};
    vecs[5] = '{1, 0, 0, -1, 0, 8, 16, 1, 1, 1};
    vecs[6] = '{4, 1, -1, -1, 0, 32, 64, 4, 4, 1};

    idle_inputs();
    #2;
    chk_zero("reset");
`ifdef DATALOAD_CTRL_TIMEOUT_EN
    chk("reset_error", error_o, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i]);
      chk($sformatf("v%0d_input_loads", i), cnt_in, vecs[i].e_in);
      chk($sformatf("v%0d_weight_loads", i), cnt_w, vecs[i].e_w);
      chk($sformatf("v%0d_compute_starts", i), cnt_comp, vecs[i].e_comp);
      chk($sformatf("v%0d_tile_cnt", i), last_tile, vecs[i].e_tile);
      chk($sformatf("v%0d_done_pulses", i), cnt_done, vecs[i].e_done);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_tile_hold", i), tile_cnt_o, vecs[i].rst_mid ? 0 : vecs[i].e_tile);
      chk($sformatf("v%0d_idle_busy", i), busy_o, 0);
    end

`ifdef DATALOAD_CTRL_TIMEOUT_EN
    begin
      int cs_at = -1, gap = -1;
      @(negedge clk);
      start_i = 1'b1; num_tiles_i = TILE_W'(1);
      src_valid_i = 1'b1; input_valid_i = 1'b1;
      weight_valid_i = 1'b1; weight_ack_i = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (compute_start_o) cs_at = c;
        if (done_o) begin gap = (cs_at < 0) ? -1 : c - cs_at; break; end
      end
      idle_inputs();
      chk("timeout_gap", gap, TO_CYC + 1);
      chk("timeout_error", error_o, 1);
      chk("timeout_busy", busy_o, 0);
      chk("timeout_tile_cnt", tile_cnt_o, 0);
      @(negedge clk);
      chk("timeout_error_sticky", error_o, 1);
      chk("timeout_done_single", done_o, 0);
      start_i = 1'b1; num_tiles_i = '0;
      @(negedge clk);
      start_i = 1'b0;
      chk("error_cleared_by_start", error_o, 0);
      repeat (2) @(negedge clk);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
